// File: rtl/yinger_pkg.sv
// Shared encodings for the Yinger MIPS multi-cycle controller: opcodes, FSM states,
// datapath mux selects and the instruction-class one-hot produced by mc_op_decode.
package yinger_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_MEM_ADDR, ST_MEM_RD,
    ST_MEM_WR, ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP
  } state_e;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OPIMM = 2'b11;

  // Bit positions in the instruction-class one-hot.
  localparam int CLS_R    = 0;
  localparam int CLS_LW   = 1;
  localparam int CLS_SW   = 2;
  localparam int CLS_BEQ  = 3;
  localparam int CLS_J    = 4;
  localparam int CLS_IMMS = 5;
  localparam int CLS_IMMZ = 6;
  localparam int CLS_ILL  = 7;
  localparam int CLS_W    = 8;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory handshake between the sequencer and the memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output iord, input mem_ack);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/mc_op_decode.sv
// Opcode to instruction-class one-hot; anything not recognised lands in CLS_ILL.
module mc_op_decode
  import yinger_pkg::*;
(
  input  logic [5:0]       opcode,
  output logic [CLS_W-1:0] cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE:                   cls[CLS_R]    = 1'b1;
      OP_LW:                      cls[CLS_LW]   = 1'b1;
      OP_SW:                      cls[CLS_SW]   = 1'b1;
      OP_BEQ:                     cls[CLS_BEQ]  = 1'b1;
      OP_J:                       cls[CLS_J]    = 1'b1;
      OP_ADDIU:                   cls[CLS_IMMS] = 1'b1;
      OP_ANDI, OP_ORI, OP_XORI:   cls[CLS_IMMZ] = 1'b1;
      default:                    cls[CLS_ILL]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: steps each instruction through fetch/decode/exec/mem/wb and
// drives the datapath selects and write enables, with a memory wait timeout.
module multicycle_ctrl
  import yinger_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [5:0]               opcode,
  input  logic                     alu_zero,
  multicycle_ctrl_if.master        mem,
  output logic                     ir_wen,
  output logic                     mdr_wen,
  output logic                     pc_wen,
  output logic [1:0]               pc_src,
  output logic                     alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic                     imm_zext,
  output logic [1:0]               alu_op,
  output logic                     rf_wen,
  output logic                     rf_dst,
  output logic                     mem_to_reg,
  output logic                     ill_inst,
  output logic                     mem_err,
  output logic                     busy
);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CLS_W-1:0] cls;
  logic             mem_state;
  logic             timeout;
  state_e           boundary;

  mc_op_decode u_dec (.opcode(opcode), .cls(cls));

  assign mem_state = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
  assign timeout   = mem_state && !mem.mem_ack && (wait_q == 8'(WAIT_MAX - 1));
  assign boundary  = run ? ST_FETCH : ST_IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_wen      = 1'b0;
    mdr_wen     = 1'b0;
    pc_wen      = 1'b0;
    pc_src      = PCSRC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REGB;
    imm_zext    = 1'b0;
    alu_op      = ALUOP_ADD;
    rf_wen      = 1'b0;
    rf_dst      = 1'b0;
    mem_to_reg  = 1'b0;
    ill_inst    = 1'b0;
    mem_err     = 1'b0;
    busy        = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = SRCB_FOUR;
        if (mem.mem_ack) begin
          ir_wen  = 1'b1;
          pc_wen  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_BROFF;
        if (cls[CLS_R])                         state_d = ST_EXEC_R;
        else if (cls[CLS_LW] || cls[CLS_SW])    state_d = ST_MEM_ADDR;
        else if (cls[CLS_BEQ])                  state_d = ST_BRANCH;
        else if (cls[CLS_J])                    state_d = ST_JUMP;
        else if (cls[CLS_IMMS] || cls[CLS_IMMZ]) state_d = ST_EXEC_I;
        else begin
          ill_inst = 1'b1;
          state_d  = boundary;
        end
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = ST_WB_R;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_OPIMM;
        imm_zext  = cls[CLS_IMMZ];
        state_d   = ST_WB_I;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = cls[CLS_SW] ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ack) begin
          mdr_wen = 1'b1;
          state_d = ST_WB_MEM;
        end
      end
      ST_MEM_WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ack) state_d = boundary;
      end
      ST_WB_R: begin
        rf_wen  = 1'b1;
        rf_dst  = 1'b1;
        state_d = boundary;
      end
      ST_WB_I: begin
        rf_wen  = 1'b1;
        state_d = boundary;
      end
      ST_WB_MEM: begin
        rf_wen     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = boundary;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_wen    = alu_zero;
        state_d   = boundary;
      end
      ST_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_wen  = 1'b1;
        state_d = boundary;
      end
      default: state_d = ST_IDLE;
    endcase

    // Timeout only fires without an ack, so no write enable is active in that cycle.
    if (timeout) begin
      mem_err = 1'b1;
      state_d = boundary;
    end else if (mem_state && !mem.mem_ack) begin
      wait_d = wait_q + 8'd1;
    end
  end

endmodule
